// File: rtl/des_round_engine.sv
// Iterative DES Feistel engine: one round per clock with an on-the-fly key schedule.
// Accepts a post-IP block and returns the preoutput R16||L16. The f-function (E, S, P)
// is external and is reached through the f_* ports.
module des_round_engine #(
   parameter int unsigned NUM_ROUNDS = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [63:0] in_block_i,
   input  logic [63:0] key_i,
   input  logic        decrypt_i,
   output logic [31:0] f_r_out_o,
   output logic [47:0] f_subkey_o,
   input  logic [31:0] f_in_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [63:0] out_block_o,
   output logic        busy_o
);

   // DES bit numbering: bit 1 is the MSB of each vector.
   localparam int unsigned PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int unsigned PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   localparam logic [4:0] LastRnd = 5'(NUM_ROUNDS - 1);

   typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] o;
      for (int i = 0; i < 56; i++) o[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
      return o;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] o;
      for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
      return o;
   endfunction

   // Shift schedule index 1..16; only rounds 1, 2, 9 and 16 shift by one.
   function automatic logic shift_two(input logic [4:0] idx);
      return !(idx == 5'd1 || idx == 5'd2 || idx == 5'd9 || idx == 5'd16);
   endfunction

   // C and D halves rotate independently.
   function automatic logic [55:0] rotl_cd(input logic [55:0] cd, input logic two);
      logic [27:0] c;
      logic [27:0] d;
      c = cd[55:28];
      d = cd[27:0];
      if (two) return {c[25:0], c[27:26], d[25:0], d[27:26]};
      return {c[26:0], c[27], d[26:0], d[27]};
   endfunction

   function automatic logic [55:0] rotr_cd(input logic [55:0] cd, input logic two);
      logic [27:0] c;
      logic [27:0] d;
      c = cd[55:28];
      d = cd[27:0];
      if (two) return {c[1:0], c[27:2], d[1:0], d[27:2]};
      return {c[0], c[27:1], d[0], d[27:1]};
   endfunction

   state_e      state_q, state_d;
   logic [31:0] l_q, l_d;
   logic [31:0] r_q, r_d;
   logic [55:0] cd_q, cd_d;
   logic [4:0]  rnd_q, rnd_d;
   logic        mode_q, mode_d;
   logic [63:0] out_block_q, out_block_d;

   logic [55:0] cd_rotl;
   logic [55:0] cd_rotr;

   // Encrypt rotates forward before use; decrypt uses CD as-is, then walks back.
   assign cd_rotl = rotl_cd(cd_q, shift_two(rnd_q + 5'd1));
   assign cd_rotr = rotr_cd(cd_q, shift_two(5'd16 - rnd_q));

   // Next-state, round datapath and handshake outputs.
   always_comb begin
      state_d     = state_q;
      l_d         = l_q;
      r_d         = r_q;
      cd_d        = cd_q;
      rnd_d       = rnd_q;
      mode_d      = mode_q;
      out_block_d = out_block_q;
      f_r_out_o   = '0;
      f_subkey_o  = '0;
      in_ready_o  = (state_q == StIdle) && !rst_i;
      out_valid_o = (state_q == StDone);
      busy_o      = (state_q == StRound) || (state_q == StDone);

      case (state_q)
         StIdle: begin
            if (in_valid_i) begin
               l_d     = in_block_i[63:32];
               r_d     = in_block_i[31:0];
               cd_d    = pc1(key_i);
               mode_d  = decrypt_i;
               rnd_d   = '0;
               state_d = StRound;
            end
         end
         StRound: begin
            f_r_out_o  = r_q;
            f_subkey_o = mode_q ? pc2(cd_q) : pc2(cd_rotl);
            l_d        = r_q;
            r_d        = l_q ^ f_in_i;
            cd_d       = mode_q ? cd_rotr : cd_rotl;
            rnd_d      = rnd_q + 5'd1;
            if (rnd_q == LastRnd) begin
               // Final swap: preoutput is R16||L16.
               out_block_d = {l_q ^ f_in_i, r_q};
               state_d     = StDone;
            end
         end
         StDone: begin
            if (out_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset taking priority over everything.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         l_q         <= '0;
         r_q         <= '0;
         cd_q        <= '0;
         rnd_q       <= '0;
         mode_q      <= 1'b0;
         out_block_q <= '0;
      end else begin
         state_q     <= state_d;
         l_q         <= l_d;
         r_q         <= r_d;
         cd_q        <= cd_d;
         rnd_q       <= rnd_d;
         mode_q      <= mode_d;
         out_block_q <= out_block_d;
      end
   end

   assign out_block_o = out_block_q;

endmodule

// File: tb/tb_des_round_engine.sv
// Scoreboard bench for des_round_engine: a full-DES reference model predicts per-round
// R/subkey pairs and the preoutput; monitors compare whenever the DUT presents them.
module tb_des_round_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_block = '0;
   logic [63:0] key = '0;
   logic        decrypt = 1'b0;
   logic [31:0] f_r_out;
   logic [47:0] f_subkey;
   logic [31:0] f_in;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_block;
   logic        busy;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   logic [63:0] exp_q [$];
   int          lat_q [$];
   logic [79:0] rk_q [$];
   logic [47:0] obs_keys [$];
   int          hs_log [$];
   logic [63:0] last_out = '0;

   localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
   localparam logic [63:0] PT   = 64'hCC00CCFFF0AAF0AA;
   localparam logic [63:0] CT   = 64'h0A4CD99543423234;
   localparam logic [47:0] K1   = 48'h1B02EFFC7072;
   localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

   int e_tab [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                      12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
   int p_tab [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                      2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
   int pc1_tab [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
   int pc2_tab [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   int shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
   int sbox [8][64] = '{
      '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
      '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
      '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
      '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
      '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
      '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
      '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
      '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}
   };

   des_round_engine #(.NUM_ROUNDS(16)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_block_i  (in_block),
      .key_i       (key),
      .decrypt_i   (decrypt),
      .f_r_out_o   (f_r_out),
      .f_subkey_o  (f_subkey),
      .f_in_i      (f_in),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_block_o (out_block),
      .busy_o      (busy)
   );

   // Cipher function f(R,K) = P(S(E(R) ^ K)).
   function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] x;
      logic [31:0] s;
      logic [31:0] o;
      logic [5:0]  six;
      int          row;
      int          col;
      for (int i = 0; i < 48; i++) x[47 - i] = r[32 - e_tab[i]];
      x = x ^ k;
      for (int b = 0; b < 8; b++) begin
         six = x[47 - 6 * b -: 6];
         row = (six[5] ? 2 : 0) + (six[0] ? 1 : 0);
         col = int'(six[4:1]);
         s[31 - 4 * b -: 4] = 4'(sbox[b][row * 16 + col]);
      end
      for (int i = 0; i < 32; i++) o[31 - i] = s[32 - p_tab[i]];
      return o;
   endfunction

   assign f_in = f_model(f_r_out, f_subkey);

   function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
      logic [55:0] t;
      t = {x, x} << n;
      return t[55:28];
   endfunction

   // Reference: all 16 subkeys from cumulative shifts, then the Feistel network.
   task automatic model_push(input logic [63:0] blk, input logic [63:0] k, input logic dec);
      logic [55:0] cd;
      logic [47:0] ks [16];
      logic [47:0] sk;
      logic [31:0] l;
      logic [31:0] r;
      logic [31:0] t;
      logic [55:0] cdr;
      int          cum;
      for (int i = 0; i < 56; i++) cd[55 - i] = k[64 - pc1_tab[i]];
      cum = 0;
      for (int i = 0; i < 16; i++) begin
         cum += shifts[i];
         cdr = {rotl28(cd[55:28], cum), rotl28(cd[27:0], cum)};
         for (int j = 0; j < 48; j++) ks[i][47 - j] = cdr[56 - pc2_tab[j]];
      end
      l = blk[63:32];
      r = blk[31:0];
      for (int rr = 0; rr < 16; rr++) begin
         sk = dec ? ks[15 - rr] : ks[rr];
         rk_q.push_back({r, sk});
         t = r;
         r = l ^ f_model(r, sk);
         l = t;
      end
      exp_q.push_back({r, l});
      lat_q.push_back(cyc + 1);
   endtask

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: cyc=%0d exceeded time limit", cyc);
      $fatal(1, "watchdog");
   end

   // Stimulus side: every accepted transaction pushes its predicted results.
   initial forever begin
      @(negedge clk);
      if (!rst && in_valid && in_ready) model_push(in_block, key, decrypt);
   end

   // Round monitor: R and subkey presented to the f-function each ROUND cycle.
   initial forever begin
      logic [79:0] rk;
      @(negedge clk);
      if (rst) begin
         rk_q.delete();
      end else if (busy && !out_valid) begin
         if (rk_q.size() == 0) begin
            chk("round_unexpected", 80'(busy), 80'd0);
         end else begin
            rk = rk_q.pop_front();
            chk("round_r", 80'(f_r_out), 80'(rk[79:48]));
            chk("round_k", 80'(f_subkey), 80'(rk[47:0]));
         end
         obs_keys.push_back(f_subkey);
      end else begin
         chk("f_idle_zero", {f_r_out, f_subkey}, 80'd0);
      end
   end

   // Output monitor: latency on rising out_valid, data on the handshake.
   initial forever begin
      logic prev;
      int   acc;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            lat_q.delete();
            prev = 1'b0;
         end else begin
            if (out_valid && !prev) begin
               if (lat_q.size() == 0) chk("out_unexpected", 80'(out_valid), 80'd0);
               else begin
                  acc = lat_q.pop_front();
                  chk("latency", 80'(cyc - acc), 80'd16);
               end
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) chk("out_unexpected", 80'(out_valid), 80'd0);
               else chk("out_block", 80'(out_block), 80'(exp_q.pop_front()));
               chk("busy_done", 80'(busy), 80'd1);
               last_out = out_block;
               hs_log.push_back(cyc + 1);
            end
            prev = out_valid;
         end
      end
   end

   task automatic send(input logic [63:0] b, input logic [63:0] k, input logic d,
                       output int acc);
      @(posedge clk);
      #1;
      in_block = b;
      key      = k;
      decrypt  = d;
      in_valid = 1'b1;
      acc      = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = cyc + 1;
            break;
         end
      end
      if (acc < 0) chk("accept_timeout", 80'(in_ready), 80'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      @(posedge clk);
      #1;
      chk("drain", 80'(exp_q.size()), 80'd0);
      chk("rounds_consumed", 80'(rk_q.size()), 80'd0);
   endtask

   initial begin
      int acc;
      int acc2;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("por_in_ready", 80'(in_ready), 80'd1);
      chk("por_outs", {out_valid, busy, out_block}, 80'd0);

      // Known-answer encrypt.
      obs_keys.delete();
      send(PT, KEY, 1'b0, acc);
      wait_done();
      chk("enc_nkeys", 80'(obs_keys.size()), 80'd16);
      chk("enc_k1", 80'(obs_keys[0]), 80'(K1));
      chk("enc_k16", 80'(obs_keys[15]), 80'(K16));
      chk("enc_kat", 80'(last_out), 80'(CT));

      // Known-answer decrypt.
      obs_keys.delete();
      send(CT, KEY, 1'b1, acc);
      wait_done();
      chk("dec_k1", 80'(obs_keys[0]), 80'(K16));
      chk("dec_k16", 80'(obs_keys[15]), 80'(K1));
      chk("dec_kat", 80'(last_out), 80'(PT));

      // Reset for two cycles from a random point in a random block.
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), acc);
      repeat ($urandom_range(2, 20)) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_in_ready0", 80'(in_ready), 80'd0);
      @(negedge clk);
      chk("rst_in_ready1", 80'(in_ready), 80'd0);
      chk("rst_outs", {out_valid, busy, out_block}, 80'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready_after", 80'(in_ready), 80'd1);
      chk("rst_outs_after", {out_valid, busy, out_block}, 80'd0);

      // Backpressure: hold DONE for five cycles while in_valid toggles.
      out_ready = 1'b0;
      send(PT, KEY, 1'b0, acc);
      for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 80'(out_valid), 80'd1);
         chk("bp_block", 80'(out_block), 80'(CT));
         chk("bp_in_ready", 80'(in_ready), 80'd0);
         @(posedge clk);
         #1;
         in_valid = (i % 2 == 0);
         in_block = {$urandom, $urandom};
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_hs_valid", 80'(out_valid), 80'd1);
      @(negedge clk);
      chk("bp_after_valid", 80'(out_valid), 80'd0);
      chk("bp_after_ready", 80'(in_ready), 80'd1);
      chk("bp_after_block", 80'(out_block), 80'(CT));
      chk("bp_rounds", 80'(rk_q.size()), 80'd0);

      // Reset sampled on the edge that would complete round 8.
      send(PT, KEY, 1'b0, acc);
      for (int i = 0; i < 40 && cyc < acc + 6; i++) @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_outs", {out_valid, busy, out_block}, 80'd0);
      chk("mid_rst_f", {f_r_out, f_subkey}, 80'd0);
      chk("mid_rst_ready", 80'(in_ready), 80'd1);
      send(PT, KEY, 1'b0, acc);
      wait_done();
      chk("mid_rst_rerun", 80'(last_out), 80'(CT));

      // Back-to-back with in_valid held high.
      hs_log.delete();
      @(posedge clk);
      #1;
      in_block = PT;
      key      = KEY;
      decrypt  = 1'b0;
      in_valid = 1'b1;
      acc      = -1;
      for (int i = 0; i < 10 && acc < 0; i++) begin
         @(negedge clk);
         if (in_ready) acc = cyc + 1;
      end
      @(posedge clk);
      #1;
      in_block = CT;
      decrypt  = 1'b1;
      acc2     = -1;
      for (int i = 0; i < 60 && acc2 < 0; i++) begin
         @(negedge clk);
         if (in_ready) acc2 = cyc + 1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_done();
      chk("b2b_hs_count", 80'(hs_log.size()), 80'd2);
      chk("b2b_gap", 80'(acc2 - hs_log[0]), 80'd1);
      chk("b2b_last", 80'(last_out), 80'(PT));

      // Randomized traffic with random backpressure and post-accept input churn.
      for (int n = 0; n < 24; n++) begin
         out_ready = 1'($urandom_range(0, 1));
         send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), acc);
         in_block = {$urandom, $urandom};
         key      = {$urandom, $urandom};
         decrypt  = 1'($urandom_range(0, 1));
         if (!out_ready) begin
            repeat ($urandom_range(10, 30)) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
         wait_done();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
